// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// State encoding, default width and counter sizing.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

  // Bit counter width; at least one bit so WIDTH=2 still works.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit full adder cell, shared across all operand bits.
// Purely combinational.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one adder cell, one bit
// per clock LSB first, start/busy/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Holds the WIDTH-1 low bits; the MSB arrives on the last edge.
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;
  logic accept;

  full_adder_1b u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Subtract mode is fully captured by the inverted B operand and
  // the initial carry, so no separate sub flop is needed.
  assign accept = start &
                  ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Next-state, datapath shift and output capture.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        res_sh_d = (WIDTH-1)'({fa_sum, res_sh_q} >> 1);
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (cnt_q == LAST) begin
          result_d = {fa_sum, res_sh_q};
          cout_d   = fa_cout;
          ovf_d    = carry_q ^ fa_cout;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = accept ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      a_sh_d   = op_a;
      b_sh_d   = sub ? ~op_b : op_b;
      carry_d  = sub;
      cnt_d    = '0;
      res_sh_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
